div_sequencer: RTL and testbench

//  CPU-side controller for the iterative divider. Accepts a divide request from EX and stalls
//  the pipeline. Drives the cycle countdown (cpu_divcy) that the division unit consumes.

---
 rtl/div_sequencer.sv | 100 ++++++++++
 tb/tb_div_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - divide sequencer: stalls EX, counts down the divider, owns HI/LO
// Optional DIV_ZERO_TRAP_EN: zero divisor raises trap_divzero instead of running the divider.
module div_sequencer #(
  parameter int DIV_CYCLES = 34,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            div_req,
  input  logic [XLEN-1:0] div_inB,
  input  logic            flush,
  input  logic            mthi_we,
  input  logic            mtlo_we,
  input  logic [XLEN-1:0] hilo_wdata,
  input  logic [XLEN-1:0] du_quo,
  input  logic [XLEN-1:0] du_rem,
  output logic [5:0]      cpu_divcy,
  output logic            div_stall,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            trap_divzero
);

  typedef enum logic [1:0] {IDLE, RUN, WRITE} state_e;

  localparam logic [5:0] DivCyInit = 6'(DIV_CYCLES);

`ifdef DIV_ZERO_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  state_e          state_q;
  logic [5:0]      divcy_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic            trap_q;
  logic            req_go;
  logic            trap_hit;

  // A request is only honoured from IDLE and a flush in the same cycle kills it.
  assign req_go   = (state_q == IDLE) && div_req && !flush;
  assign trap_hit = TrapEn && (div_inB == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      divcy_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      trap_q  <= 1'b0;
    end else begin
      trap_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_go) begin
            if (trap_hit) begin
              trap_q <= 1'b1;
            end else begin
              state_q <= RUN;
              divcy_q <= DivCyInit;
            end
          end else if (!flush) begin
            if (mthi_we) hi_q <= hilo_wdata;
            if (mtlo_we) lo_q <= hilo_wdata;
          end
        end
        RUN: begin
          if (flush) begin
            state_q <= IDLE;
            divcy_q <= '0;
          end else if (divcy_q == 6'd1) begin
            state_q <= WRITE;
            divcy_q <= '0;
          end else begin
            divcy_q <= divcy_q - 6'd1;
          end
        end
        WRITE: begin
          // Result commits even under flush; the divide has already retired.
          lo_q    <= du_quo;
          hi_q    <= du_rem;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          divcy_q <= '0;
        end
      endcase
    end
  end

  assign div_stall    = (state_q != IDLE) || req_go;
  assign cpu_divcy    = divcy_q;
  assign hi           = hi_q;
  assign lo           = lo_q;
  assign trap_divzero = trap_q;

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - directed self-checking bench for div_sequencer
// Models the division unit: du_quo/du_rem are valid only while cpu_divcy is 0.
module tb_div_sequencer;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            div_req;
  logic [XLEN-1:0] div_inB;
  logic            flush;
  logic            mthi_we;
  logic            mtlo_we;
  logic [XLEN-1:0] hilo_wdata;
  logic [XLEN-1:0] du_quo;
  logic [XLEN-1:0] du_rem;
  logic [5:0]      cpu_divcy;
  logic            div_stall;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            trap_divzero;

  logic [XLEN-1:0] quo_val;
  logic [XLEN-1:0] rem_val;

  int checks = 0;
  int errors = 0;

  div_sequencer dut (
    .clk(clk), .reset(reset), .div_req(div_req), .div_inB(div_inB), .flush(flush),
    .mthi_we(mthi_we), .mtlo_we(mtlo_we), .hilo_wdata(hilo_wdata),
    .du_quo(du_quo), .du_rem(du_rem), .cpu_divcy(cpu_divcy), .div_stall(div_stall),
    .hi(hi), .lo(lo), .trap_divzero(trap_divzero)
  );

  always #5 clk = ~clk;

  assign du_quo = (cpu_divcy == 6'd0) ? quo_val : 32'hBAD0_BAD0;
  assign du_rem = (cpu_divcy == 6'd0) ? rem_val : 32'hBAD1_BAD1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_divcy(input logic [5:0] v);
    int n = 0;
    while (cpu_divcy !== v && n < 100) begin
      tick();
      n++;
    end
    check("wait_divcy", {26'd0, cpu_divcy}, {26'd0, v});
  endtask

  initial begin
    reset = 1'b1; div_req = 1'b0; div_inB = '0; flush = 1'b0;
    mthi_we = 1'b0; mtlo_we = 1'b0; hilo_wdata = '0; quo_val = '0; rem_val = '0;
    tick();
    check("rst_divcy", {26'd0, cpu_divcy}, 32'd0);
    check("rst_stall", {31'd0, div_stall}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_trap", {31'd0, trap_divzero}, 32'd0);
    reset = 1'b0;
    tick();

    // 1: reset in the middle of a run
    div_req = 1'b1; div_inB = 32'd7;
    tick();
    div_req = 1'b0;
    wait_divcy(6'd20);
    reset = 1'b1;
    #1;
    check("t1_divcy", {26'd0, cpu_divcy}, 32'd0);
    check("t1_stall", {31'd0, div_stall}, 32'd0);
    check("t1_hi", hi, 32'd0);
    check("t1_lo", lo, 32'd0);
    #1 reset = 1'b0;
    tick();

    // 2: full divide, 14 r 2
    quo_val = 32'd14; rem_val = 32'd2;
    div_req = 1'b1; div_inB = 32'd7;
    #1;
    check("t2_req_stall", {31'd0, div_stall}, 32'd1);
    tick();
    div_req = 1'b0;
    check("t2_divcy34", {26'd0, cpu_divcy}, 32'd34);
    for (int i = 33; i >= 1; i--) begin
      tick();
      check("t2_count", {26'd0, cpu_divcy}, i);
      check("t2_run_stall", {31'd0, div_stall}, 32'd1);
    end
    tick();
    check("t2_write_divcy", {26'd0, cpu_divcy}, 32'd0);
    check("t2_write_stall", {31'd0, div_stall}, 32'd1);
    check("t2_write_lo_old", lo, 32'd0);
    tick();
    check("t2_lo", lo, 32'd14);
    check("t2_hi", hi, 32'd2);
    check("t2_stall_low", {31'd0, div_stall}, 32'd0);

    // 3: MTHI/MTLO together, then dropped under a request
    mthi_we = 1'b1; mtlo_we = 1'b1; hilo_wdata = 32'hDEAD_BEEF;
    tick();
    check("t3_hi", hi, 32'hDEAD_BEEF);
    check("t3_lo", lo, 32'hDEAD_BEEF);
    hilo_wdata = 32'h1234_5678; div_req = 1'b1; div_inB = 32'd3;
    tick();
    div_req = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
    check("t3_drop_hi", hi, 32'hDEAD_BEEF);
    check("t3_drop_lo", lo, 32'hDEAD_BEEF);
    check("t3_run", {26'd0, cpu_divcy}, 32'd34);

    // 4: flush during RUN abandons the divide
    quo_val = 32'h55; rem_val = 32'h66;
    wait_divcy(6'd10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_divcy", {26'd0, cpu_divcy}, 32'd0);
    check("t4_stall", {31'd0, div_stall}, 32'd0);
    tick();
    tick();
    check("t4_hi", hi, 32'hDEAD_BEEF);
    check("t4_lo", lo, 32'hDEAD_BEEF);

    // 5: MTLO during RUN ignored; WRITE loads the quotient
    quo_val = 32'd100; rem_val = 32'd3;
    div_req = 1'b1; div_inB = 32'd5;
    tick();
    div_req = 1'b0;
    mtlo_we = 1'b1; hilo_wdata = 32'h1111_1111;
    tick();
    mtlo_we = 1'b0;
    check("t5_lo_run", lo, 32'hDEAD_BEEF);
    wait_divcy(6'd0);
    check("t5_lo_write", lo, 32'hDEAD_BEEF);
    tick();
    check("t5_lo", lo, 32'd100);
    check("t5_hi", hi, 32'd3);

    // 6: zero divisor
    quo_val = 32'd9; rem_val = 32'd9;
    div_req = 1'b1; div_inB = 32'd0;
    #1;
    check("t6_req_stall", {31'd0, div_stall}, 32'd1);
    tick();
    div_req = 1'b0;
`ifdef DIV_ZERO_TRAP_EN
    check("t6_trap", {31'd0, trap_divzero}, 32'd1);
    check("t6_divcy", {26'd0, cpu_divcy}, 32'd0);
    check("t6_stall", {31'd0, div_stall}, 32'd0);
    tick();
    check("t6_trap_pulse", {31'd0, trap_divzero}, 32'd0);
    check("t6_lo", lo, 32'd100);
    check("t6_hi", hi, 32'd3);
`else
    check("t6_trap", {31'd0, trap_divzero}, 32'd0);
    check("t6_divcy", {26'd0, cpu_divcy}, 32'd34);
    wait_divcy(6'd0);
    tick();
    check("t6_lo", lo, 32'd9);
    check("t6_hi", hi, 32'd9);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
